// File: rtl/gauss_frame_ctrl_pkg.sv
// Shared types and constants for the Gaussian frame controller.
// Holds the FSM state enum, the RGB565 pixel type and border geometry.
package gauss_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } ctrl_state_t;

    typedef logic [15:0] rgb565_t;

    localparam int BORDER_COLS = 2;
    localparam int BORDER_ROWS = 2;

    // Sync + pixel bundle carried through the alignment delay line.
    typedef struct packed {
        logic    hs;
        logic    vs;
        logic    de;
        rgb565_t data;
    } vid_t;

    function automatic rgb565_t border_fill(
        input logic    black,
        input rgb565_t raw
    );
        return black ? 16'h0000 : raw;
    endfunction

endpackage

// File: rtl/gauss_frame_ctrl_if.sv
// Pixel stream bundle: raw input, filter result and aligned output.
// slave = controller side, master = source/sink side.
interface gauss_frame_ctrl_if;
    import gauss_ctrl_pkg::*;

    logic    in_hs;
    logic    in_vs;
    logic    in_de;
    rgb565_t in_data;
    rgb565_t flt_data;
    logic    out_hs;
    logic    out_vs;
    logic    out_de;
    rgb565_t out_data;

    modport slave (
        input  in_hs, in_vs, in_de, in_data, flt_data,
        output out_hs, out_vs, out_de, out_data
    );

    modport master (
        output in_hs, in_vs, in_de, in_data, flt_data,
        input  out_hs, out_vs, out_de, out_data
    );

endinterface

// File: rtl/gauss_frame_ctrl_sync_delay_line.sv
// Fixed-depth shift register aligning sync and raw pixel to the filter.
// Ports: clk, rst_n, i_d[W-1:0] in, o_q[W-1:0] out (DEPTH cycles later).
module sync_delay_line #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [DEPTH-1:0][W-1:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/gauss_frame_ctrl.sv
// Frame/line sequencer for the RGB565 3x3 Gaussian filter datapath.
// Ports: clk, rst_n, cfg_bypass, cfg_border, vif (pixel stream, slave),
//   lb_flush, row_cnt, col_cnt, state, err_len.
// Optional GAUSS_FRAME_STAT_EN adds frame_cnt[15:0] and line_total[9:0].
module gauss_frame_ctrl
    import gauss_ctrl_pkg::*;
#(
    parameter int   H_ACTIVE = 480,
    parameter int   V_ACTIVE = 272,
    parameter int   PIPE_DLY = 4,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_bypass,
    input  logic        cfg_border,
    gauss_frame_ctrl_if.slave vif,
    output logic        lb_flush,
    output logic [9:0]  row_cnt,
    output logic [9:0]  col_cnt,
    output logic [1:0]  state,
    output logic        err_len
`ifdef GAUSS_FRAME_STAT_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [9:0]  line_total
`endif
);

    localparam logic [9:0] LP_H     = 10'(H_ACTIVE);
    localparam logic [9:0] LP_VMAX  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] LP_BCOLS = 10'(BORDER_COLS);
    localparam logic [9:0] LP_BROW  = 10'(BORDER_ROWS - 1);

    vid_t        w_din;
    vid_t        w_d;
    logic        w_fs;
    logic        w_de_fall;
    logic        w_bypass;
    logic        w_border;
    logic        w_border_px;
    logic [9:0]  w_row;
    logic [9:0]  w_col;
    ctrl_state_t w_state_eff;
    rgb565_t     w_pix;

    ctrl_state_t r_state;
    logic        r_vs_prev;
    logic        r_de_prev;
    logic        r_bypass;
    logic        r_border;
    logic        r_lb_flush;
    logic        r_err;
    logic [9:0]  r_row;
    logic [9:0]  r_col;
    logic        r_out_hs;
    logic        r_out_vs;
    logic        r_out_de;
    rgb565_t     r_out_data;
    logic [9:0]  r_row_o;
    logic [9:0]  r_col_o;

    assign w_din = {vif.in_hs, vif.in_vs, vif.in_de, vif.in_data};

    sync_delay_line #(
        .W     ($bits(vid_t)),
        .DEPTH (PIPE_DLY)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_din),
        .o_q   (w_d)
    );

    assign w_fs      = (w_d.vs == VS_POL) && (r_vs_prev != VS_POL);
    assign w_de_fall = r_de_prev && !w_d.de;

    // Frame start wins over everything else on the same cycle, so the
    // pixel at fs already sees the new config and row/col 0.
    assign w_bypass    = w_fs ? cfg_bypass : r_bypass;
    assign w_border    = w_fs ? cfg_border : r_border;
    assign w_row       = w_fs ? 10'd0 : r_row;
    assign w_col       = w_fs ? 10'd0 : r_col;
    assign w_state_eff = w_fs ? PRIME : r_state;

    assign w_border_px = (w_state_eff != RUN) || (w_col < LP_BCOLS);

    always_comb begin
        w_pix = vif.flt_data;
        if (w_bypass) begin
            w_pix = w_d.data;
        end else if (w_border_px) begin
            w_pix = border_fill(w_border, w_d.data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_fs) r_state <= PRIME;
                end
                PRIME: begin
                    if (w_fs) begin
                        r_state <= PRIME;
                    end else if (w_de_fall && r_row == LP_BROW) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_fs) r_state <= PRIME;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Counters stay frozen in IDLE so row reads 0 until the first fs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev  <= VS_POL;
            r_de_prev  <= 1'b0;
            r_bypass   <= 1'b0;
            r_border   <= 1'b0;
            r_lb_flush <= 1'b0;
            r_err      <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
        end else begin
            r_vs_prev  <= w_d.vs;
            r_de_prev  <= w_d.de;
            r_lb_flush <= w_fs;
            if (w_fs) begin
                r_bypass <= cfg_bypass;
                r_border <= cfg_border;
                r_err    <= 1'b0;
                r_row    <= '0;
                r_col    <= w_d.de ? 10'd1 : 10'd0;
            end else if (r_state != IDLE) begin
                if (w_d.de) begin
                    r_col <= r_col + 10'd1;
                end else if (w_de_fall) begin
                    if (r_col != LP_H) r_err <= 1'b1;
                    r_col <= '0;
                    if (r_row != LP_VMAX) r_row <= r_row + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_hs   <= 1'b0;
            r_out_vs   <= 1'b0;
            r_out_de   <= 1'b0;
            r_out_data <= '0;
            r_row_o    <= '0;
            r_col_o    <= '0;
        end else begin
            r_out_hs   <= w_d.hs;
            r_out_vs   <= w_d.vs;
            r_out_de   <= w_d.de;
            r_out_data <= w_d.de ? w_pix : 16'h0000;
            r_row_o    <= w_row;
            r_col_o    <= w_d.de ? w_col : 10'd0;
        end
    end

`ifdef GAUSS_FRAME_STAT_EN
    logic [15:0] r_frame_cnt;
    logic [9:0]  r_lines;
    logic [9:0]  r_line_total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt  <= '0;
            r_lines      <= '0;
            r_line_total <= '0;
        end else if (w_fs) begin
            r_frame_cnt  <= r_frame_cnt + 16'd1;
            r_line_total <= r_lines;
            r_lines      <= '0;
        end else if (r_state != IDLE && w_de_fall && r_lines != 10'h3FF) begin
            r_lines <= r_lines + 10'd1;
        end
    end

    assign frame_cnt  = r_frame_cnt;
    assign line_total = r_line_total;
`endif

    assign vif.out_hs   = r_out_hs;
    assign vif.out_vs   = r_out_vs;
    assign vif.out_de   = r_out_de;
    assign vif.out_data = r_out_data;
    assign lb_flush     = r_lb_flush;
    assign row_cnt      = r_row_o;
    assign col_cnt      = r_col_o;
    assign state        = r_state;
    assign err_len      = r_err;

endmodule

// File: doc/gauss_frame_ctrl.md
Name: gauss_frame_ctrl

Overview:
- Frame and line sequencer for the RGB565 3x3 Gaussian filter datapath. It sits between the camera/SDRAM read stream and the LCD timing output.
- Tracks row and column position and pulses the line-buffer flush at each frame start.
- Aligns the raw pixel and sync signals with the filter result, then decides per pixel whether the output is the filtered value, the raw value, or black.
- Owns the bypass and border configuration, which is shadowed once per frame.

Parameters:
- H_ACTIVE, 480, active pixels per line
- V_ACTIVE, 272, active lines per frame
- PIPE_DLY, 4, cycles from in_* to flt_data valid (filter pipeline depth)
- VS_POL, 1, active level of in_vs

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- cfg_bypass  in  1  1 = pass raw pixels through
- cfg_border  in  1  border fill: 0 = raw pixel, 1 = 16'h0000
- in_hs / in_vs / in_de  in  1 each  input sync and data enable
- in_data  in  16  raw RGB565 pixel
- flt_data  in  16  filter output, valid PIPE_DLY cycles after the matching in_data
- lb_flush  out  1  one-cycle pulse clearing the line buffers
- out_hs / out_vs / out_de  out  1 each  aligned sync and data enable
- out_data  out  16  selected pixel
- row_cnt  out  10  line index of the pixel currently at the output stage
- col_cnt  out  10  column index of the pixel currently at the output stage
- state  out  2  FSM state, for debug
- err_len  out  1  sticky flag: a line length differed from H_ACTIVE

Behaviour:
- Reset values: every output is 0; state is IDLE; shadow config is cleared to bypass=0, border=0.
- Alignment:
  - in_hs, in_vs, in_de and in_data pass through a PIPE_DLY shift register, giving d_hs, d_vs, d_de and d_data.
  - Output stage is one registered cycle, so total latency in_* -> out_* is PIPE_DLY+1.
  - flt_data is sampled on the same edge as d_data.
- Frame start (fs): d_vs transitions into its VS_POL level.
  - lb_flush goes high for one cycle, the cycle after fs is detected.
  - cfg_bypass and cfg_border are copied into shadow registers on fs only. Mid-frame changes to the cfg_* inputs are ignored.
  - row_cnt and col_cnt clear to 0; err_len clears.
- Counters (run on d_de):
  - col_cnt increments on each d_de=1 cycle.
  - On the falling edge of d_de: if the run length is not H_ACTIVE, err_len is set. Then col_cnt clears and row_cnt increments.
  - row_cnt saturates at V_ACTIVE-1; extra lines do not wrap.
- FSM:
  - IDLE -> PRIME on fs.
  - PRIME -> RUN when the d_de falling edge completes row 1.
  - RUN -> PRIME on fs. This restarts the frame, including a truncated frame; lb_flush is issued.
  - Any state -> IDLE on reset only.
- Pixel selection, registered into out_data when d_de=1:
  - Shadow bypass=1: d_data.
  - State IDLE or PRIME, or col_cnt<2: border fill.
  - Otherwise: flt_data.
  - When d_de=0, out_data = 0.
- out_hs, out_vs and out_de are always d_hs, d_vs and d_de, registered one cycle. They are never gated, even in IDLE, so LCD timing is preserved.
- Simultaneous fs and d_de=1: fs takes priority. Counters clear and that pixel is counted as col 0 of row 0.
- Reset mid-frame: all state is lost. The block waits in IDLE for the next fs and outputs raw/black per the border rules with row=0.

Optional Feature:
- GAUSS_FRAME_STAT_EN.
- When defined:
  - Adds output frame_cnt[15:0], which increments on each fs and wraps at 16'hFFFF -> 0.
  - Adds output line_total[9:0], which latches the row count reached at each fs, before counters clear.
- When undefined: these ports and their registers are absent, and all other behaviour is identical.

Decomposition:
- Package gauss_ctrl_pkg holds:
  - typedef enum logic [1:0] {IDLE, PRIME, RUN} ctrl_state_t
  - typedef logic [15:0] rgb565_t
  - localparam BORDER_COLS = 2, BORDER_ROWS = 2
- One natural sub-module: sync_delay_line, a parameterised-width, PIPE_DLY-deep shift register carrying {hs, vs, de, data}.

Test Plan:
- Reset: hold rst_n=0 while driving sync activity -> all outputs 0 and state=IDLE. Release rst_n, then run 10 idle cycles -> still IDLE.
- Full 480x272 frame, cfg_bypass=0, cfg_border=1, flt_data=16'hAAAA, in_data=16'h5555:
  - rows 0-1 and cols 0-1 -> 16'h0000
  - all other pixels -> 16'hAAAA
  - out_de is exactly in_de delayed 5 cycles
- cfg_bypass toggled to 1 in the middle of row 100 -> current frame stays filtered; the next frame outputs 16'h5555 everywhere.
- Line of 479 pixels in row 50 -> err_len=1 from the end of row 50 until the next fs, then 0.
- fs asserted during row 120 (truncated frame) -> lb_flush pulses once, state=PRIME, row_cnt=0; the following two lines output border fill.
- With GAUSS_FRAME_STAT_EN defined, 3 frames -> frame_cnt=3 and line_total=272.
